// File: rtl/arm_decode_pkg.sv
// Shared ARM decode definitions: class/subtype codes, the decoded-record type
// and the combinational classifier used at queue push.
package arm_decode_pkg;

    localparam logic [1:0] CLS_OTHER  = 2'b00;
    localparam logic [1:0] CLS_DATA   = 2'b01;
    localparam logic [1:0] CLS_MEM    = 2'b10;
    localparam logic [1:0] CLS_BRANCH = 2'b11;

    localparam logic [2:0] DSUB_NONE      = 3'b000;
    localparam logic [2:0] DSUB_IMM       = 3'b001;
    localparam logic [2:0] DSUB_SHIFT_IMM = 3'b010;
    localparam logic [2:0] DSUB_SHIFT_REG = 3'b011;
    localparam logic [2:0] DSUB_MUL       = 3'b100;

    localparam logic [2:0] MSUB_IMM = 3'b001;
    localparam logic [2:0] MSUB_REG = 3'b010;

    localparam logic [2:0] BSUB_B  = 3'b001;
    localparam logic [2:0] BSUB_BL = 3'b010;

    typedef struct packed {
        logic [1:0]  cls;
        logic [2:0]  sub;
        logic [3:0]  cond;
        logic        uncond;
        logic [31:0] instr;
    } dec_rec_t;

    function automatic dec_rec_t decode_instr(input logic [31:0] w);
        dec_rec_t r;
        r        = '0;
        r.cls    = CLS_OTHER;
        r.sub    = DSUB_NONE;
        r.cond   = w[31:28];
        r.uncond = (w[31:28] == 4'b1111);
        r.instr  = w;
        if (w[27:25] == 3'b101) begin
            r.cls = CLS_BRANCH;
            r.sub = w[24] ? BSUB_BL : BSUB_B;
        end else if (w[27:26] == 2'b01) begin
            r.cls = CLS_MEM;
            r.sub = w[25] ? MSUB_REG : MSUB_IMM;
        end else if (w[27:26] == 2'b00) begin
            r.cls = CLS_DATA;
            // Multiply shares the register-shift encoding space, so it must win first.
            if (w[27:22] == 6'b000000 && w[7:4] == 4'b1001) r.sub = DSUB_MUL;
            else if (w[25])                                 r.sub = DSUB_IMM;
            else if (!w[4])                                 r.sub = DSUB_SHIFT_IMM;
            else if (!w[7])                                 r.sub = DSUB_SHIFT_REG;
            else                                            r.sub = DSUB_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/arm_decode_queue_if.sv
// Fetch/issue handshake bundle of the decode queue; statistics signals exist
// only when DECODE_STATS_EN is defined.
interface arm_decode_queue_if #(
    parameter int DEPTH = 4
`ifdef DECODE_STATS_EN
    , parameter int CNT_W = 16
`endif
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_instr;
    logic                     out_valid;
    logic                     out_ready;
    logic [1:0]               out_class;
    logic [2:0]               out_sub;
    logic [3:0]               out_cond;
    logic                     out_uncond;
    logic [31:0]              out_instr;
    logic [$clog2(DEPTH):0]   occupancy;
`ifdef DECODE_STATS_EN
    logic                     stat_clr;
    logic [CNT_W-1:0]         stat_data;
    logic [CNT_W-1:0]         stat_mem;
    logic [CNT_W-1:0]         stat_branch;
    logic [CNT_W-1:0]         stat_other;
`endif

    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_class, out_sub, out_cond, out_uncond,
               out_instr, occupancy
`ifdef DECODE_STATS_EN
        , output stat_clr
        , input  stat_data, stat_mem, stat_branch, stat_other
`endif
    );

    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_class, out_sub, out_cond, out_uncond,
               out_instr, occupancy
`ifdef DECODE_STATS_EN
        , input  stat_clr
        , output stat_data, stat_mem, stat_branch, stat_other
`endif
    );

endinterface

// File: rtl/arm_decode_fifo.sv
// DEPTH-entry FIFO of decoded records with registered ready, synchronous flush
// and occupancy count; no bypass path when full.
module arm_decode_fifo
    import arm_decode_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  dec_rec_t               push_data,
    output logic                   pop_valid,
    input  logic                   pop_ready,
    output dec_rec_t               pop_data,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

    dec_rec_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [PTR_W:0]     count_nxt;
    logic               ready_q;
    logic               push;
    logic               pop;

    assign push = push_valid && ready_q && !flush;
    assign pop  = pop_valid && pop_ready && !flush;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            count   <= count_nxt;
            ready_q <= (count_nxt != FULL_CNT);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign push_ready = ready_q;
    assign pop_valid  = (count != '0);
    assign pop_data   = mem[rd_ptr];
    assign occupancy  = count;

endmodule

// File: rtl/arm_decode_queue.sv
// Registered ARM decode queue: classifies each accepted word and buffers the
// record; DECODE_STATS_EN adds saturating per-class accept counters.
module arm_decode_queue
    import arm_decode_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef DECODE_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    arm_decode_queue_if.slave  bus
);
    dec_rec_t in_rec;
    dec_rec_t head_rec;
    dec_rec_t vis_rec;
    logic     push_ready;
    logic     head_valid;

    assign in_rec = decode_instr(bus.in_instr);

    arm_decode_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (bus.flush),
        .push_valid (bus.in_valid),
        .push_ready (push_ready),
        .push_data  (in_rec),
        .pop_valid  (head_valid),
        .pop_ready  (bus.out_ready),
        .pop_data   (head_rec),
        .occupancy  (bus.occupancy)
    );

    // Head fields read as zero while nothing is queued, hiding stale storage.
    assign vis_rec        = head_valid ? head_rec : '0;
    assign bus.in_ready   = push_ready;
    assign bus.out_valid  = head_valid;
    assign bus.out_class  = vis_rec.cls;
    assign bus.out_sub    = vis_rec.sub;
    assign bus.out_cond   = vis_rec.cond;
    assign bus.out_uncond = vis_rec.uncond;
    assign bus.out_instr  = vis_rec.instr;

`ifdef DECODE_STATS_EN
    logic             accept;
    logic [CNT_W-1:0] stat_cnt [4];

    assign accept = bus.in_valid && push_ready && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) stat_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.stat_clr)
                    stat_cnt[i] <= '0;
                else if (accept && in_rec.cls == 2'(i) && stat_cnt[i] != '1)
                    stat_cnt[i] <= stat_cnt[i] + 1'b1;
            end
        end
    end

    assign bus.stat_other  = stat_cnt[CLS_OTHER];
    assign bus.stat_data   = stat_cnt[CLS_DATA];
    assign bus.stat_mem    = stat_cnt[CLS_MEM];
    assign bus.stat_branch = stat_cnt[CLS_BRANCH];
`endif

endmodule
